// File: rtl/flipflops_pkg.sv
// Shared definitions for the flip_flops register bank: default width and the
// set of flop flavours a dff_cell can be built as.
package flipflops_pkg;

  localparam int DEFAULT_WIDTH = 1;

  typedef enum logic [1:0] {
    FF_PLAIN,
    FF_SYNC_CLR,
    FF_ASYNC_CLR_PRE
  } ff_kind_e;

endpackage

// File: rtl/flip_flops_dff_cell.sv
// dff_cell: one WIDTH-bit D register whose control flavour is chosen by KIND.
//   FF_PLAIN         : sync active-low reset, then d
//   FF_SYNC_CLR      : sync active-low reset, then sync active-high clear, then d
//   FF_ASYNC_CLR_PRE : async active-low clear (wins), async active-low preset,
//                      then sync active-low reset, then d
// Controls that a flavour does not use are ignored; the parent ties them inactive.
module dff_cell
  import flipflops_pkg::*;
#(
  parameter ff_kind_e KIND  = FF_PLAIN,
  parameter int       WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             sclr,
  input  logic             aclr_n,
  input  logic             pre_n,
  output logic [WIDTH-1:0] q
);

  // Controls not consumed by the selected flavour are folded here so every
  // elaboration reads all of its inputs.
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, sclr, aclr_n, pre_n};

  generate
    if (KIND == FF_ASYNC_CLR_PRE) begin : g_async_clr_pre
      // Async clear beats async preset; both beat the synchronous reset.
      always_ff @(posedge clk or negedge aclr_n or negedge pre_n) begin
        if (!aclr_n) begin
          q <= '0;
        end else if (!pre_n) begin
          q <= '1;
        end else if (!rst_n) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end
    end else if (KIND == FF_SYNC_CLR) begin : g_sync_clr
      // Reset first, then the synchronous clear, then load.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q <= '0;
        end else if (sclr) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end
    end else begin : g_plain
      // Plain register with synchronous reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/flip_flops.sv
// flip_flops: bank of three parallel D registers sharing clk and D, each with
// a different control flavour (plain / sync clear / async clear+preset).
// Optional macro FLIPFLOPS_QN_EN adds inverted outputs Q1n/Q2n/Q3n that follow
// their Q combinationally, including during async clear/preset.
module flip_flops
  import flipflops_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_ff2,
  input  logic             clr_ff3,
  input  logic             pre_ff3,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
`ifdef FLIPFLOPS_QN_EN
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q1n,
  output logic [WIDTH-1:0] Q2n,
  output logic [WIDTH-1:0] Q3n
`else
  output logic [WIDTH-1:0] Q3
`endif
);

  dff_cell #(.KIND(FF_PLAIN), .WIDTH(WIDTH)) u_ff1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (D),
    .sclr   (1'b0),
    .aclr_n (1'b1),
    .pre_n  (1'b1),
    .q      (Q1)
  );

  dff_cell #(.KIND(FF_SYNC_CLR), .WIDTH(WIDTH)) u_ff2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (D),
    .sclr   (clr_ff2),
    .aclr_n (1'b1),
    .pre_n  (1'b1),
    .q      (Q2)
  );

  dff_cell #(.KIND(FF_ASYNC_CLR_PRE), .WIDTH(WIDTH)) u_ff3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (D),
    .sclr   (1'b0),
    .aclr_n (clr_ff3),
    .pre_n  (pre_ff3),
    .q      (Q3)
  );

`ifdef FLIPFLOPS_QN_EN
  assign Q1n = ~Q1;
  assign Q2n = ~Q2;
  assign Q3n = ~Q3;
`endif

endmodule

// File: tb/tb_flip_flops.sv
// Testbench for flip_flops: directed scenarios followed by random stimulus,
// compared against a rule-level model of the three registers.
module tb_flip_flops;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] D = '0;
  logic         clr_ff2 = 1'b0;
  logic         clr_ff3 = 1'b1;
  logic         pre_ff3 = 1'b1;
  logic [W-1:0] Q1, Q2, Q3;
`ifdef FLIPFLOPS_QN_EN
  logic [W-1:0] Q1n, Q2n, Q3n;
`endif

  flip_flops #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .clr_ff2 (clr_ff2),
    .clr_ff3 (clr_ff3),
    .pre_ff3 (pre_ff3),
    .Q1      (Q1),
    .Q2      (Q2),
`ifdef FLIPFLOPS_QN_EN
    .Q3      (Q3),
    .Q1n     (Q1n),
    .Q2n     (Q2n),
    .Q3n     (Q3n)
`else
    .Q3      (Q3)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: expected register contents.
  logic [W-1:0] m1, m2, m3;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q1"}, Q1, m1);
    check({tag, ".q2"}, Q2, m2);
    check({tag, ".q3"}, Q3, m3);
`ifdef FLIPFLOPS_QN_EN
    check({tag, ".q1n"}, Q1n, ~m1);
    check({tag, ".q2n"}, Q2n, ~m2);
    check({tag, ".q3n"}, Q3n, ~m3);
`endif
  endtask

  // Drive inputs mid-cycle, check the async effect on Q3 before the edge,
  // then check all outputs just after the edge.
  task automatic step(input string tag, input logic [W-1:0] d, input logic r,
                      input logic c2, input logic c3, input logic p3,
                      input bit chk_pre);
    @(negedge clk);
    D = d; rst_n = r; clr_ff2 = c2; clr_ff3 = c3; pre_ff3 = p3;
    if (!c3)      m3 = '0;
    else if (!p3) m3 = '1;
    #1;
    if (chk_pre) begin
      check({tag, ".pre.q3"}, Q3, m3);
`ifdef FLIPFLOPS_QN_EN
      check({tag, ".pre.q3n"}, Q3n, ~m3);
`endif
    end
    @(posedge clk);
    m1 = r ? d : '0;
    m2 = (!r || c2) ? '0 : d;
    if (!c3)      m3 = '0;
    else if (!p3) m3 = '1;
    else          m3 = r ? d : '0;
    #1;
    check_all(tag);
  endtask

  localparam logic [W-1:0] ONES = '1;

  initial begin
    // Reset state
    step("reset", ONES, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // Plain flop: D = 0, 1, 0
    step("plain0", '0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("plain1", ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("plain2", '0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Sync clear on flop 2
    step("sclr_ld", ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("sclr_hold", ONES, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sclr_d0", '0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sclr_d1", ONES, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sclr_rel", ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Async clear on flop 3, D toggling while held
    step("aclr_ld", ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("aclr_hold", (i % 2 == 0) ? ONES : '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step("aclr_rel", 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Async preset on flop 3
    step("pre_ld0", '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("pre_hold", '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("pre_hold", '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("pre_rel", '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("pre_d1", ONES, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Clear beats preset
    step("both_low", ONES, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("both_rel", 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Reset with D=1, then reset while preset is asserted
    step("rst_d1", ONES, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("rst_pre", ONES, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("rst_clr", ONES, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("post_rst", 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      step("rand", W'($urandom),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) != 0),
           1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d done", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
